// File: rtl/bp_pkg.sv
// Shared definitions for the beq direction predictor: opcodes, counter states,
// the shadow pipeline entry and the B-type immediate decoder.
package bp_pkg;

   localparam logic [6:0] BEQ_OP     = 7'b1100011;
   localparam logic [2:0] FUNCT3_BEQ = 3'b000;

   // Storage width of PC/target inside a shadow entry; the top narrows on use.
   localparam int unsigned SHADOW_PC_W = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   typedef struct packed {
      logic                   valid;
      logic                   pred;
      logic [SHADOW_PC_W-1:0] pc;
      logic [SHADOW_PC_W-1:0] target;
   } shadow_t;

   // Sign-extended B-type branch offset, {imm[12:1], 1'b0}.
   function automatic logic [31:0] b_imm(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter; the MSB is the taken prediction.
module sat_counter2
   import bp_pkg::*;
#(
   parameter cnt_e RST_VAL = WNT
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_taken
);

   cnt_e r_cnt;

   // Increment has priority; the owner never requests both at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= RST_VAL;
      end else if (i_inc && (r_cnt != ST)) begin
         r_cnt <= cnt_e'(r_cnt + 2'd1);
      end else if (i_dec && (r_cnt != SNT)) begin
         r_cnt <= cnt_e'(r_cnt - 2'd1);
      end
   end

   assign o_taken = r_cnt[1];

endmodule

// File: rtl/beq_predictor.sv
// Bimodal beq predictor: predicts in IF, tracks predictions through shadow
// IF/ID and ID/EX stages, resolves in EX and drives redirect/mispredict.
module beq_predictor
   import bp_pkg::*;
#(
   parameter int unsigned IDX_BITS = 4,
   parameter int unsigned PC_W     = 32,
   parameter int unsigned CNT_W    = 16
)(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [PC_W-1:0]  PC_IF,
   input  logic [31:0]      INSTR_IF,
   input  logic             STALL,
   input  logic             BR_TAKEN_EX,
   output logic             PRED_TAKEN_IF,
   output logic [PC_W-1:0]  PRED_TARGET_IF,
   output logic             BEQ_WRONG_PRED,
   output logic [PC_W-1:0]  REDIRECT_PC,
   output logic [6:0]       OP_CODE_EX,
   output logic [CNT_W-1:0] BR_COUNT,
   output logic [CNT_W-1:0] MISS_COUNT
);

   localparam int unsigned TBL_N = 2 ** IDX_BITS;

   logic [TBL_N-1:0]    w_tbl_msb;
   logic [IDX_BITS-1:0] w_if_idx;
   logic [IDX_BITS-1:0] w_upd_idx;
   logic                w_is_beq;
   logic                w_pred;
   logic [PC_W-1:0]     w_target;
   logic [PC_W-1:0]     w_ex_pc;
   logic                w_ex_valid;
   logic                w_wrong;
   logic                w_inc;
   logic                w_dec;
   logic                w_unused_instr;
   shadow_t             w_if_entry;
   shadow_t             w_ifid_nxt;
   shadow_t             w_idex_nxt;
   shadow_t             r_ifid;
   shadow_t             r_idex;
   logic [CNT_W-1:0]    r_br_cnt;
   logic [CNT_W-1:0]    r_miss_cnt;

   // Register-field bits of the instruction play no part in prediction.
   assign w_unused_instr = ^INSTR_IF[24:15];

   // IF: decode, index and target
   assign w_is_beq = (INSTR_IF[6:0] == BEQ_OP) && (INSTR_IF[14:12] == FUNCT3_BEQ);
   assign w_if_idx = PC_IF[IDX_BITS+1:2];
   assign w_pred   = w_is_beq & w_tbl_msb[w_if_idx];
   assign w_target = PC_IF + PC_W'(b_imm(INSTR_IF));

   assign PRED_TAKEN_IF  = w_pred;
   assign PRED_TARGET_IF = w_target;

   assign w_if_entry = '{valid:  w_is_beq,
                         pred:   w_pred,
                         pc:     SHADOW_PC_W'(PC_IF),
                         target: SHADOW_PC_W'(w_target)};

   // EX: resolve the tracked prediction against the compare result
   assign w_ex_valid = r_idex.valid;
   assign w_ex_pc    = PC_W'(r_idex.pc);
   assign w_wrong    = w_ex_valid & (BR_TAKEN_EX != r_idex.pred);
   assign w_upd_idx  = w_ex_pc[IDX_BITS+1:2];
   assign w_inc      = w_ex_valid &  BR_TAKEN_EX;
   assign w_dec      = w_ex_valid & ~BR_TAKEN_EX;

   assign BEQ_WRONG_PRED = w_wrong;
   assign OP_CODE_EX     = w_ex_valid ? BEQ_OP : 7'd0;

   always_comb begin
      REDIRECT_PC = '0;
      if (w_ex_valid) begin
         REDIRECT_PC = BR_TAKEN_EX ? PC_W'(r_idex.target) : (w_ex_pc + PC_W'(4));
      end
   end

   // Counter table; writes land at the edge, so a same-index IF read sees the old value.
   for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
      logic w_hit;
      assign w_hit = (w_upd_idx == IDX_BITS'(gi));

      sat_counter2 #(
         .RST_VAL (WNT)
      ) u_cnt (
         .clk     (CLK),
         .rst_n   (RST_N),
         .i_inc   (w_inc & w_hit),
         .i_dec   (w_dec & w_hit),
         .o_taken (w_tbl_msb[gi])
      );
   end

   // Shadow next state: a mispredict flush overrides the stall hold.
   always_comb begin
      w_ifid_nxt = r_ifid;
      w_idex_nxt = r_idex;
      if (w_wrong) begin
         w_ifid_nxt       = w_if_entry;
         w_ifid_nxt.valid = 1'b0;
         w_idex_nxt       = r_ifid;
         w_idex_nxt.valid = 1'b0;
      end else if (STALL) begin
         w_idex_nxt.valid = 1'b0;
      end else begin
         w_ifid_nxt = w_if_entry;
         w_idex_nxt = r_ifid;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ifid <= '0;
         r_idex <= '0;
      end else begin
         r_ifid <= w_ifid_nxt;
         r_idex <= w_idex_nxt;
      end
   end

   // Resolved-branch and mispredict statistics, wrapping
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else if (w_ex_valid) begin
         r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (w_wrong) begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

   assign BR_COUNT   = r_br_cnt;
   assign MISS_COUNT = r_miss_cnt;

endmodule

// File: doc/beq_predictor.md
Name: beq_predictor

Overview:
- Produces the BEQ_WRONG_PRED input consumed by the hazard unit.
- Predicts beq direction in IF with a bimodal table of 2-bit saturating counters indexed by PC.
- Carries each prediction through shadow IF/ID and ID/EX registers. These honour the hazard unit's STALL/bubble.
- Resolves the prediction in EX against the ALU compare result, updates the table, and emits the redirect PC and mispredict flag.

Parameters:
- IDX_BITS, 4: table index width; 2^IDX_BITS counters.
- PC_W, 32: PC/address width.
- CNT_W, 16: width of the branch and mispredict statistics counters.

Ports:
- CLK, input, 1: rising-edge clock.
- RST_N, input, 1: asynchronous active-low reset.
- PC_IF, input, PC_W: PC of the instruction in fetch.
- INSTR_IF, input, 32: fetched instruction word.
- STALL, input, 1: from the hazard unit. Holds the IF/ID shadow stage and inserts a bubble into ID/EX.
- BR_TAKEN_EX, input, 1: beq compare result (rs1==rs2) for the instruction in EX.
- PRED_TAKEN_IF, output, 1: predict taken for the instruction in IF.
- PRED_TARGET_IF, output, PC_W: PC_IF + sign-extended B-immediate.
- BEQ_WRONG_PRED, output, 1: the EX-stage beq was mispredicted.
- REDIRECT_PC, output, PC_W: correct next PC, valid when BEQ_WRONG_PRED=1.
- OP_CODE_EX, output, 7: opcode of the EX shadow entry (1100011 or 0). Feeds the hazard unit's OP_CODE.
- BR_COUNT, output, CNT_W: resolved beq count.
- MISS_COUNT, output, CNT_W: mispredict count.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All counters set to 2'b01 (weakly not-taken).
  - Shadow valid bits cleared; shadow PC/target set to 0.
  - BR_COUNT and MISS_COUNT set to 0.
  - Outputs: PRED_TAKEN_IF=0, BEQ_WRONG_PRED=0, REDIRECT_PC=0, OP_CODE_EX=0.
  - A reset mid-operation discards all in-flight predictions.
- IF prediction (combinational):
  - is_beq = INSTR_IF[6:0]==1100011 && INSTR_IF[14:12]==000.
  - idx = PC_IF[IDX_BITS+1:2].
  - PRED_TAKEN_IF = is_beq & table[idx][1].
  - PRED_TARGET_IF = PC_IF + {sign-extended imm[12:1],0}, with imm = {I[31],I[7],I[30:25],I[11:8]}. Computed modulo 2^PC_W; wrap-around is allowed.
- Shadow pipeline, each entry {valid, pred, pc, target}:
  - IF/ID: loads is_beq/pred/PC_IF/target each cycle. Holds when STALL=1.
  - ID/EX: loads from IF/ID. Loads valid=0 (bubble) when STALL=1.
- EX resolution (combinational), when the ID/EX entry is valid:
  - BEQ_WRONG_PRED = (BR_TAKEN_EX != pred).
  - REDIRECT_PC = BR_TAKEN_EX ? target : pc+4.
  - If the entry is invalid: BEQ_WRONG_PRED=0 and REDIRECT_PC=0.
- Update, at the clock edge when the ID/EX entry is valid:
  - table[pc idx] increments if taken (saturates at 11), else decrements (saturates at 00).
  - BR_COUNT+1; MISS_COUNT+1 on a mispredict. Both wrap modulo 2^CNT_W.
- Flush: when BEQ_WRONG_PRED=1, both IF/ID and ID/EX valid bits are cleared at the next edge, since the younger instructions are wrong-path.
- Simultaneous events:
  - Mispredict and STALL in the same cycle: the flush wins.
  - EX update and IF read of the same index: IF sees the pre-update value (no bypass).
  - Two consecutive beqs to the same index: each updates in its own EX cycle, in order.
- Latency: prediction in 0 cycles (IF); resolution 2 cycles after IF, absent stalls.

Decomposition:
- Package bp_pkg holds:
  - BEQ_OP = 7'b1100011 and FUNCT3_BEQ = 3'b000.
  - Counter encodings SNT/WNT/WT/ST = 00/01/10/11.
  - Typedef shadow_t {valid, pred, pc, target}.
  - Function b_imm(instr) returning the sign-extended offset.
- One sub-module, sat_counter2: a 2-bit saturating counter with inc/dec enable, instantiated per table entry via generate. The shadow pipeline stays in the top.

Test Plan:
- Reset, then beq at PC=0x40 with offset +16 → PRED_TAKEN_IF=0, PRED_TARGET_IF=0x50. Two cycles later with BR_TAKEN_EX=1 → BEQ_WRONG_PRED=1, REDIRECT_PC=0x50, table[0]=10, MISS_COUNT=1.
- Same beq taken 3 more times → predicted taken from the second iteration on, counter saturates at 11, BR_COUNT=4, MISS_COUNT=1. A not-taken outcome then gives mispredict, REDIRECT_PC=0x44, counter=10.
- beq in IF/ID with STALL=1 for 2 cycles → ID/EX is a bubble for those cycles (BEQ_WRONG_PRED=0, no update). The branch resolves exactly once afterwards.
- Mispredict in EX while the next instruction is also a beq → that younger beq's shadow entry is flushed and does not update the table or BR_COUNT.
- Mispredict coincident with STALL=1 → both shadow stages are invalid next cycle, and the hold is not applied.
- Assert RST_N low while a beq sits in ID/EX → outputs are 0 immediately (asynchronous). After release, no update occurs and all counters read 01.
